rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (W_ADDR/Din/WE) among NUM_REQ writeback requesters, e.g. ALU writeback and load writeback.
- Uses round-robin arbitration with per-requester valid/ack handshakes.
- Registers the winning write into the register file with a fixed 1-cycle latency.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on registers whose writes are still outstanding.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_wb_arbiter_rr.sv | 54 +++++
 rtl/rf_wb_arbiter.sv | 110 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants for the writeback arbiter and its users.
//   REG_COUNT : number of architectural registers (size of the busy scoreboard)
//   ADDR_W    : register address width
//   DATA_W    : register data width
//   ZERO_REG  : hard-wired zero register, never written
package rf_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef logic [REG_COUNT-1:0] busy_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin arbiter with a rotating last-grant pointer.
//   clk_i       : rising-edge clock
//   rst_i       : synchronous active-high reset; forces gnt_o to zero and the
//                 pointer to NUM_REQ-1 so requester 0 is favoured first
//   req_i       : one bit per requester
//   gnt_o       : one-hot grant (combinational)
//   gnt_valid_o : any grant this cycle
//   gnt_idx_o   : index of the granted requester
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [IdxW-1:0]    gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  // Search starts just after the last winner and wraps; first hit wins.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    if (!rst_i) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
        if (!gnt_valid_o && req_i[cand]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = cand;
          gnt_o[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = gnt_valid_o ? gnt_idx_o : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IdxW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback
// requesters and tracks outstanding writes in a busy scoreboard.
//   clk, rst        : clock, synchronous active-high reset
//   req/req_addr/
//   req_data        : per-requester write requests (packed, requester i in
//                     slice i)
//   ack             : one-hot combinational grant; request consumed on the edge
//   rsv_valid/addr  : issue stage reserves a destination register
//   W_ADDR/Din/WE   : registered register-file write port
//   busy            : registered scoreboard of reserved, unwritten registers
//   conflict        : registered pulse when a reserve hits a busy register
module rf_wb_arbiter
  import rf_pkg::REG_COUNT;
  import rf_pkg::ZERO_REG;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic [ADDR_W-1:0]         W_ADDR,
  output logic [DATA_W-1:0]         Din,
  output logic                      WE,
  output logic [REG_COUNT-1:0]      busy,
  output logic                      conflict
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  logic            gnt_valid;
  logic [IdxW-1:0] gnt_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (ack),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  logic [ADDR_W-1:0]    gnt_addr;
  logic [DATA_W-1:0]    gnt_data;
  logic                 wr_real, rsv_real;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic                 we_q, we_d;
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic                 conflict_q, conflict_d;

  always_comb begin
    gnt_addr = addr_arr[gnt_idx];
    gnt_data = data_arr[gnt_idx];
    // Register 0 writes are still acked but never reach the register file.
    wr_real  = gnt_valid && (gnt_addr != ADDR_W'(ZERO_REG));
    rsv_real = rsv_valid && (rsv_addr != ADDR_W'(ZERO_REG));

    we_d    = wr_real;
    waddr_d = gnt_valid ? gnt_addr : waddr_q;
    din_d   = gnt_valid ? gnt_data : din_q;

    // Clear first so a same-cycle reserve of the same register wins.
    busy_d = busy_q;
    if (wr_real) busy_d[gnt_addr] = 1'b0;
    if (rsv_real) busy_d[rsv_addr] = 1'b1;

    // A register being retired this very cycle is free for the new reserve.
    conflict_d = rsv_real && busy_q[rsv_addr] && !(wr_real && (gnt_addr == rsv_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      waddr_q    <= '0;
      din_q      <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign WE       = we_q;
  assign W_ADDR   = waddr_q;
  assign Din      = din_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    ack;
  logic             rsv_valid;
  logic [AW-1:0]    rsv_addr;
  logic [AW-1:0]    W_ADDR;
  logic [DW-1:0]    Din;
  logic             WE;
  logic [31:0]      busy;
  logic             conflict;

  rf_wb_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack       (ack),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .W_ADDR    (W_ADDR),
    .Din       (Din),
    .WE        (WE),
    .busy      (busy),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_din;
  logic [31:0] m_busy;
  logic        m_conf;

  logic [NR-1:0] last_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, check combinational ack, advance model at the
  // edge, then check all registered outputs.
  task automatic step(input logic rst_v, input logic [NR-1:0] r,
                      input logic [NR*AW-1:0] ra, input logic [NR*DW-1:0] rd,
                      input logic rv, input logic [AW-1:0] rsa);
    int gi;
    int clr;
    logic [NR-1:0] m_ack;
    logic [AW-1:0] a;
    logic [31:0] nb;
    @(negedge clk);
    rst = rst_v; req = r; req_addr = ra; req_data = rd; rsv_valid = rv; rsv_addr = rsa;
    #1;
    gi = -1;
    m_ack = '0;
    if (!rst_v) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (gi < 0 && r[c]) gi = c;
      end
    end
    if (gi >= 0) m_ack[gi] = 1'b1;
    last_ack = ack;
    chk("ack", 32'(ack), 32'(m_ack));
    @(posedge clk);
    if (rst_v) begin
      m_ptr = NR - 1; m_we = 0; m_wa = '0; m_din = '0; m_busy = '0; m_conf = 0;
    end else begin
      clr = -1;
      m_conf = 0;
      m_we = 0;
      if (gi >= 0) begin
        a = ra[gi*AW +: AW];
        m_wa = a;
        m_din = rd[gi*DW +: DW];
        m_ptr = gi;
        if (a != 0) begin
          m_we = 1;
          clr = int'(a);
        end
      end
      nb = m_busy;
      if (clr >= 0) nb[clr] = 1'b0;
      if (rv && rsa != 0) begin
        m_conf = m_busy[rsa] && (clr != int'(rsa));
        nb[rsa] = 1'b1;
      end
      m_busy = nb;
    end
    #1;
    chk("WE", 32'(WE), 32'(m_we));
    chk("W_ADDR", 32'(W_ADDR), 32'(m_wa));
    chk("Din", Din, m_din);
    chk("busy", busy, m_busy);
    chk("conflict", 32'(conflict), 32'(m_conf));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [NR-1:0]    r;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    rst = 1; req = '0; req_addr = '0; req_data = '0; rsv_valid = 0; rsv_addr = '0;
    m_ptr = NR - 1; m_we = 0; m_wa = '0; m_din = '0; m_busy = '0; m_conf = 0;

    // Reset with requests present: nothing may be acked.
    step(1'b1, 2'b11, {5'd2, 5'd1}, '0, 1'b1, 5'd4);
    chk("rst_ack", 32'(last_ack), 32'h0);
    step(1'b1, 2'b00, '0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) idle();
    chk("idle_we", 32'(WE), 32'h0);
    chk("idle_busy", busy, 32'h0);

    // Single request
    step(1'b0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEADBEEF}, 1'b0, '0);
    chk("single_ack", 32'(last_ack), 32'h1);
    chk("single_we", 32'(WE), 32'h1);
    chk("single_waddr", 32'(W_ADDR), 32'h3);
    chk("single_din", Din, 32'hDEADBEEF);
    idle();
    chk("single_we_off", 32'(WE), 32'h0);
    chk("single_din_hold", Din, 32'hDEADBEEF);

    // Both requesters held: strict alternation starting at requester 0.
    step(1'b1, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11, {5'd5, 5'd4}, {32'h55, 32'h44}, 1'b0, '0);
      chk("alt_ack", 32'(last_ack), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_we", 32'(WE), 32'h1);
      chk("alt_waddr", 32'(W_ADDR), (i % 2 == 0) ? 32'h4 : 32'h5);
    end
    idle();

    // Scoreboard
    step(1'b0, 2'b00, '0, '0, 1'b1, 5'd7);
    chk("rsv7_busy", busy, 32'h80);
    step(1'b0, 2'b00, '0, '0, 1'b1, 5'd7);
    chk("rsv7_conflict", 32'(conflict), 32'h1);
    chk("rsv7_busy_keep", busy, 32'h80);
    step(1'b0, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h77}, 1'b0, '0);
    chk("wr7_busy", busy, 32'h0);
    chk("wr7_conflict", 32'(conflict), 32'h0);
    step(1'b0, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 1'b1, 5'd9);
    chk("setclr9_busy", busy, 32'h200);
    step(1'b0, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h9A}, 1'b1, 5'd9);
    chk("setclr9b_busy", busy, 32'h200);
    chk("setclr9b_conflict", 32'(conflict), 32'h0);

    // Register 0
    step(1'b0, 2'b00, '0, '0, 1'b1, 5'd0);
    chk("rsv0_busy", busy, 32'h200);
    step(1'b0, 2'b10, {5'd6, 5'd0}, {32'h66, 32'h0}, 1'b0, '0);
    chk("r0_pre_ack", 32'(last_ack), 32'h2);
    step(1'b0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, 1'b0, '0);
    chk("r0_ack", 32'(last_ack), 32'h1);
    chk("r0_we", 32'(WE), 32'h0);
    step(1'b0, 2'b11, {5'd6, 5'd0}, {32'h66, 32'h0}, 1'b0, '0);
    chk("r0_ptr_adv", 32'(last_ack), 32'h2);

    // Reset mid-stream
    step(1'b0, 2'b01, {5'd0, 5'd12}, {32'h0, 32'hC}, 1'b1, 5'd13);
    chk("mid_we", 32'(WE), 32'h1);
    step(1'b1, 2'b11, {5'd6, 5'd8}, {32'h6, 32'h8}, 1'b0, '0);
    chk("mid_rst_ack", 32'(last_ack), 32'h0);
    chk("mid_rst_we", 32'(WE), 32'h0);
    chk("mid_rst_busy", busy, 32'h0);
    step(1'b0, 2'b11, {5'd6, 5'd8}, {32'h6, 32'h8}, 1'b0, '0);
    chk("post_rst_ack", 32'(last_ack), 32'h1);

    // Randomized traffic; requesters hold their request until acked.
    r = '0; ra = '0; rd = '0;
    for (int c = 0; c < 3000; c++) begin
      logic rs;
      for (int i = 0; i < NR; i++) begin
        if (!r[i] || last_ack[i]) begin
          r[i] = ($urandom_range(0, 3) != 0);
          ra[i*AW +: AW] = AW'($urandom_range(0, 15));
          rd[i*DW +: DW] = $urandom;
        end
      end
      rs = ($urandom_range(0, 99) == 0);
      step(rs, r, ra, rd, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
